// File: rtl/deframe_and_diff_dec.sv
// Receive deframer: differential decode of the demodulated bit stream, sync-word hunt,
// extraction of one even-parity payload byte per frame, one-entry valid/ready output buffer.
module deframe_and_diff_dec #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    SYNC_WIDTH = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 16'hEB90
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  demod_frame_valid,
  input  logic                  demod_frame_data,
  input  logic                  uart_frame_ready,
  output logic                  frame_uart_valid,
  output logic [DATA_WIDTH-1:0] frame_uart_data,
  output logic                  frame_err,
  output logic                  frame_ovf
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_DATA,
    S_PARITY
  } state_t;

  state_t                  state_q, state_d;
  logic                    prev_q, prev_d;
  logic [SYNC_WIDTH-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   buf_q, buf_d;
  logic                    vld_q, vld_d;
  logic                    err_q, err_d;
  logic                    ovf_q, ovf_d;

  logic                    bit_b;
  logic                    xfer;
  logic                    frame_good;
  logic                    frame_bad;

  // Even parity over the payload plus the received parity bit.
  function automatic logic even_parity_ok(input logic [DATA_WIDTH-1:0] data,
                                          input logic                  par);
    return ~(^data ^ par);
  endfunction

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    vld_d      = vld_q;
    err_d      = 1'b0;
    ovf_d      = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;

    bit_b = demod_frame_data ^ prev_q;
    xfer  = vld_q & uart_frame_ready;

    if (xfer) begin
      vld_d = 1'b0;
    end

    if (demod_frame_valid) begin
      prev_d = demod_frame_data;
      case (state_q)
        S_HUNT: begin
          sreg_d = {sreg_q[SYNC_WIDTH-2:0], bit_b};
          if (sreg_d == SYNC_WORD) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          shift_d = {shift_q[DATA_WIDTH-2:0], bit_b};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          // Clearing the hunt register keeps tail bits of this frame from faking a sync.
          state_d = S_HUNT;
          sreg_d  = '0;
          if (even_parity_ok(shift_q, bit_b)) begin
            frame_good = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end
        default: begin
          state_d = S_HUNT;
        end
      endcase
    end

    err_d = frame_bad;
    if (frame_good) begin
      // A byte leaving on this same edge frees the slot for the new one.
      if (!vld_q || xfer) begin
        buf_d = shift_q;
        vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_HUNT;
      prev_q  <= 1'b0;
      sreg_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  // Payload shifter is always fully rewritten before use, so it carries no reset.
  always_ff @(posedge sys_clk) begin
    shift_q <= shift_d;
  end

  assign frame_uart_valid = vld_q;
  assign frame_uart_data  = buf_q;
  assign frame_err        = err_q;
  assign frame_ovf        = ovf_q;

endmodule

// File: tb/tb_deframe_and_diff_dec.sv
// Bench for deframe_and_diff_dec: a frame-level reference model predicts the outputs after
// every clock edge into a scoreboard queue; a monitor pops and compares each cycle.
module tb_deframe_and_diff_dec;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       demod_frame_valid = 1'b0;
  logic       demod_frame_data = 1'b0;
  logic       uart_frame_ready = 1'b0;
  logic       frame_uart_valid;
  logic [7:0] frame_uart_data;
  logic       frame_err;
  logic       frame_ovf;

  deframe_and_diff_dec dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .demod_frame_valid(demod_frame_valid),
    .demod_frame_data (demod_frame_data),
    .uart_frame_ready (uart_frame_ready),
    .frame_uart_valid (frame_uart_valid),
    .frame_uart_data  (frame_uart_data),
    .frame_err        (frame_err),
    .frame_ovf        (frame_ovf)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e;
    logic       o;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state: decoded-bit window while hunting, payload bits while in a frame.
  logic       m_prev;
  bit         hist[$];
  bit         pay[$];
  bit         in_frame;
  logic       m_full;
  logic [7:0] m_byte;

  // Stimulus-side state.
  logic enc_prev = 1'b0;
  logic rdy = 1'b0;
  bit   rnd_rdy = 0;
  bit   rnd_gap = 0;

  task automatic model_step(input logic v, input logic d, input logic r, input logic rs);
    exp_t       e;
    logic       b;
    logic       xf;
    logic [15:0] w;
    logic [7:0] by;
    int         ones;
    bit         good, badf;
    good = 0;
    badf = 0;
    e.e  = 1'b0;
    e.o  = 1'b0;
    if (rs) begin
      m_prev   = 1'b0;
      hist.delete();
      pay.delete();
      in_frame = 0;
      m_full   = 1'b0;
      m_byte   = 8'h00;
    end else begin
      xf = m_full & r;
      if (v) begin
        b      = d ^ m_prev;
        m_prev = d;
        if (!in_frame) begin
          hist.push_back(b);
          if (hist.size() > 16) void'(hist.pop_front());
          if (hist.size() == 16) begin
            w = '0;
            for (int i = 0; i < 16; i++) w = {w[14:0], hist[i]};
            if (w == 16'hEB90) begin
              in_frame = 1;
              pay.delete();
            end
          end
        end else begin
          pay.push_back(b);
          if (pay.size() == 9) begin
            by   = '0;
            ones = 0;
            for (int i = 0; i < 8; i++) by = {by[6:0], pay[i]};
            for (int i = 0; i < 9; i++) ones += int'(pay[i]);
            if (ones % 2 == 0) good = 1;
            else badf = 1;
            in_frame = 0;
            hist.delete();
          end
        end
      end
      e.e = badf;
      if (good) begin
        if (!m_full || xf) begin
          m_byte = by;
          m_full = 1'b1;
        end else begin
          e.o = 1'b1;
        end
      end else if (xf) begin
        m_full = 1'b0;
      end
    end
    e.v = m_full;
    e.d = m_byte;
    sb.push_back(e);
  endtask

  task automatic cycle(input logic v, input logic d, input logic r, input logic rs);
    @(negedge sys_clk);
    demod_frame_valid = v;
    demod_frame_data  = d;
    uart_frame_ready  = r;
    rst               = rs;
    @(posedge sys_clk);
    model_step(v, d, r, rs);
  endtask

  function automatic logic pick_rdy();
    return rnd_rdy ? logic'($urandom_range(0, 1)) : rdy;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, logic'($urandom_range(0, 1)), pick_rdy(), 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    enc_prev = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic r, input bit tog);
    logic d;
    if (rnd_gap) idle($urandom_range(0, 2));
    d = enc_prev ^ b;
    enc_prev = d;
    cycle(1'b1, d, r, 1'b0);
    if (tog) idle(1);
  endtask

  task automatic send_bits(input logic [15:0] val, input int n, input bit tog);
    for (int i = n - 1; i >= 0; i--) send_bit(val[i], pick_rdy(), tog);
  endtask

  task automatic send_frame(input logic [7:0] by, input bit flip, input logic pr, input bit tog);
    send_bits(16'hEB90, 16, tog);
    send_bits({8'h00, by}, 8, tog);
    send_bit((^by) ^ flip, pr, tog);
  endtask

  task automatic send_noise(input int n, input bit tog);
    for (int i = 0; i < n; i++) send_bit(logic'($urandom_range(0, 1)), pick_rdy(), tog);
  endtask

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp("valid", {7'b0, frame_uart_valid}, {7'b0, e.v});
      cmp("data", frame_uart_data, e.d);
      cmp("err", {7'b0, frame_err}, {7'b0, e.e});
      cmp("ovf", {7'b0, frame_ovf}, {7'b0, e.o});
    end
  end

  initial begin
    do_reset(3);
    rdy = 1'b1;
    idle(2);

    // Clean frame, always ready.
    send_frame(8'h5A, 0, 1'b1, 0);
    idle(3);
    // Same frame, bad parity.
    send_frame(8'h5A, 1, 1'b1, 0);
    idle(3);

    // Back-to-back frames, no ready: second is dropped with overflow, then a single ready pulse.
    rdy = 1'b0;
    send_frame(8'h3C, 0, 1'b0, 0);
    send_frame(8'hC3, 0, 1'b0, 0);
    idle(2);
    rdy = 1'b1;
    idle(1);
    rdy = 1'b0;
    idle(2);

    // Ready only on the second frame's load edge: transfer and load together.
    send_frame(8'h3C, 0, 1'b0, 0);
    send_frame(8'hC3, 0, 1'b1, 0);
    idle(1);
    rdy = 1'b1;
    idle(2);

    // Truncated sync among noise, valid toggling every cycle.
    send_noise(14, 1);
    send_bits(16'h0EB9, 12, 1);
    send_noise(14, 1);
    send_frame(8'h69, 0, 1'b1, 1);
    idle(3);

    // Buffered byte plus partial frame wiped by reset, then a clean frame.
    rdy = 1'b0;
    send_frame(8'h11, 0, 1'b0, 0);
    send_bits(16'hEB90, 16, 0);
    send_bits(16'h00B4, 7, 0);
    do_reset(2);
    rdy = 1'b1;
    send_frame(8'hA7, 0, 1'b1, 0);
    idle(3);

    // Random frames, gaps, noise, parity errors and ready.
    rnd_rdy = 1;
    rnd_gap = 1;
    for (int k = 0; k < 30; k++) begin
      send_noise($urandom_range(0, 20), 0);
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), pick_rdy(), 0);
      idle($urandom_range(0, 4));
    end
    rnd_rdy = 0;
    rnd_gap = 0;
    rdy = 1'b1;
    idle(4);

    @(negedge sys_clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
